grant_decoder: RTL and testbench
================================

Name: grant_decoder

Overview:
- Sequential 2-to-4 grant decoder: the downstream end of the arbiter's 4-to-2 priority encoder.
- Samples the encoded winner {V,Y}, drives a registered one-hot Grant to the winning requester, and holds it until that requester drops its request or a timeout fires.
- Inserts a fixed bus turnaround gap before accepting the next winner.
- Sits between the priority encoder and the four bus masters.

Parameters:
- TIMEOUT, 16: maximum cycles a grant is held; 0 disables the timeout.
- TURN_CYC, 1: dead cycles with Grant=0 between grants; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Y  input  2  encoded winner index; requester i is encoded as i (Req[0] has highest priority upstream).
- V  input  1  winner valid; 1 means Y is meaningful.
- Req  input  4  raw request lines from the masters.
- Grant  output  4  registered one-hot grant; at most one bit set.
- Owner  output  2  index of the current or last grant holder.
- Busy  output  1  high in GRANT and TURN.
- Timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset: asynchronous, active-low. Sets state to IDLE and clears Grant, Owner, Busy, Timeout, the hold counter and the turn counter to 0. Deassertion is used synchronously on the next clk edge.
- States: IDLE, GRANT, TURN. Grant and Owner are registered; Busy and Timeout are registered.
- IDLE:
  - Grant=0, Busy=0.
  - At an edge with V=1 and Req[Y]=1: Owner<=Y, Grant<=1<<Y, hold counter<=0, state->GRANT. Grant is therefore visible 1 cycle after V is sampled.
  - At an edge with V=1 and Req[Y]=0 (stale encode): no action; stay in IDLE.
  - V=0: stay in IDLE.
- GRANT:
  - Grant holds onehot(Owner). Y and V are ignored.
  - The hold counter increments each edge while in GRANT and saturates at TIMEOUT-1.
  - Edge with Req[Owner]=0: Grant<=0, turn counter<=0, state->TURN, Timeout stays 0.
  - Edge with Req[Owner]=1, counter==TIMEOUT-1 and TIMEOUT!=0: Grant<=0, Timeout<=1 for exactly one cycle, state->TURN. Maximum grant length is TIMEOUT cycles.
  - Release and timeout on the same edge: release wins and no Timeout pulse is produced.
  - Changes on Req bits other than Owner have no effect.
- TURN:
  - Grant=0, Busy=1.
  - The turn counter increments each edge. When it equals TURN_CYC-1: state->IDLE, Busy<=0.
  - The first possible sample of V happens in the IDLE cycle that follows.
- Owner retains its value after release and changes only at the next accepted grant.
- Grant is guaranteed never to be multi-hot and never to change bits without passing through at least TURN_CYC all-zero cycles.
- Reset mid-GRANT: Grant drops to 0 immediately (asynchronously). Timeout is not pulsed.
- Counter widths: hold counter is wide enough for TIMEOUT-1 (5 bits for the default); turn counter is 4 bits.

Test Plan:
- Reset: hold rst_n=0 while Req=4'b1111, V=1, Y=2'b01 -> Grant=0, Owner=0, Busy=0, Timeout=0. Release rst_n; next edge accepts -> Grant=4'b0010, Owner=1 one cycle later.
- Basic grant/release: Req=4'b0100, {V,Y}=3'b110 sampled at edge k -> Grant=4'b0100 and Busy=1 after edge k. Drop Req[2] after 5 cycles -> Grant=0 at the next edge; Busy=0 after TURN_CYC=1 further cycle; next grant no earlier than 2 cycles after release.
- Timeout: Req=4'b0001 held high, {V,Y}=3'b100, TIMEOUT=16 -> Grant=4'b0001 for exactly 16 cycles, then Grant=0 with a single-cycle Timeout=1. Busy=1 through the following TURN cycle.
- Simultaneous release and timeout: drop Req[0] on exactly the 16th grant cycle -> Grant=0, Timeout stays 0.
- Ignore while busy: during a grant to requester 3, drive {V,Y}=3'b100 with Req=4'b1001 -> Grant stays 4'b1000, Owner=3. After Req[3] drops and the turn gap -> Grant=4'b0001.
- Stale encode and mid-grant reset: {V,Y}=3'b101 with Req=4'b0000 -> remains IDLE, Grant=0. Then grant requester 1 and pull rst_n low mid-GRANT -> Grant=0 within the same cycle, state IDLE, Owner=0.

Source files
------------

// File: rtl/grant_decoder.sv
// -----------------------------------------------------------------------------
// grant_decoder
//
// Sequential 2-to-4 grant decoder at the downstream end of the arbiter.
// It samples the encoded winner {V,Y} and drives a registered one-hot Grant
// to the winning master. The grant is held until that master drops its
// request or the hold timeout fires. A fixed bus turnaround gap separates
// consecutive grants.
//
// Parameters
//   TIMEOUT   maximum number of cycles a grant is held (0 disables the timeout)
//   TURN_CYC  number of all-zero Grant cycles after a release (1..15)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   Y        in   [1:0] encoded winner index
//   V        in   winner valid
//   Req      in   [3:0] raw request lines from the masters
//   Grant    out  [3:0] registered one-hot grant
//   Owner    out  [1:0] index of the current or last grant holder
//   Busy     out  high while granting or in the turnaround gap
//   Timeout  out  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module grant_decoder #(
    parameter int TIMEOUT  = 16,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Y,
    input  logic       V,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic [1:0] Owner,
    output logic       Busy,
    output logic       Timeout
);

    // The hold counter must be able to hold TIMEOUT-1; keep at least 1 bit so
    // the design still elaborates with the timeout disabled.
    localparam int HOLD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]        TURN_MAX = 4'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          turn_q, turn_d;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          owner_q, owner_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    // One-hot image of the incoming winner index.
    logic [3:0] y_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_y_dec
            assign y_onehot[gi] = (Y == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                // A valid encode whose request has already gone away is stale
                // and is dropped without leaving IDLE.
                if (V && Req[Y]) begin
                    owner_d = Y;
                    grant_d = y_onehot;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end
            end

            S_GRANT: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
                // A voluntary release takes precedence over the timeout, so a
                // master dropping its request on the last allowed cycle never
                // sees a Timeout pulse.
                if (!Req[owner_q]) begin
                    grant_d = 4'b0000;
                    turn_d  = 4'd0;
                    state_d = S_TURN;
                end else if ((TIMEOUT != 0) && (hold_q == HOLD_MAX)) begin
                    grant_d   = 4'b0000;
                    turn_d    = 4'd0;
                    timeout_d = 1'b1;
                    state_d   = S_TURN;
                end
            end

            S_TURN: begin
                grant_d = 4'b0000;
                if (turn_q == TURN_MAX) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end

            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            turn_q    <= 4'd0;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign Grant   = grant_q;
    assign Owner   = owner_q;
    assign Busy    = busy_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_grant_decoder.sv
module tb_grant_decoder;

    localparam int TIMEOUT  = 16;
    localparam int TURN_CYC = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] Y;
    logic       V;
    logic [3:0] Req;
    logic [3:0] Grant;
    logic [1:0] Owner;
    logic       Busy;
    logic       Timeout;

    int n_vec;
    int n_bad;

    // Reference model: "is someone granted, who, for how many cycles so far,
    // how many gap cycles remain, did this edge force a release".
    int m_active;
    int m_owner;
    int m_held;
    int m_gap;
    int m_to;

    grant_decoder #(
        .TIMEOUT (TIMEOUT),
        .TURN_CYC(TURN_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Y      (Y),
        .V      (V),
        .Req    (Req),
        .Grant  (Grant),
        .Owner  (Owner),
        .Busy   (Busy),
        .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_active = 0;
        m_owner  = 0;
        m_held   = 0;
        m_gap    = 0;
        m_to     = 0;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic v, input logic [1:0] y);
        m_to = 0;
        if (m_active != 0) begin
            m_held = m_held + 1;
            if (req[m_owner] == 1'b0) begin
                m_active = 0;
                m_gap    = TURN_CYC;
            end else if (TIMEOUT != 0 && m_held >= TIMEOUT) begin
                m_active = 0;
                m_gap    = TURN_CYC;
                m_to     = 1;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (v && req[y]) begin
            m_active = 1;
            m_owner  = int'(y);
            m_held   = 0;
        end
    endfunction

    // Expected {Grant, Owner, Busy, Timeout}
    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        g = (m_active != 0) ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), ((m_active != 0) || (m_gap > 0)), (m_to != 0)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {Grant, Owner, Busy, Timeout};
    endfunction

    // Apply inputs for one cycle, advance the model on the same edge, then
    // settle just after the edge so outputs are sampled away from it.
    task automatic tick(input logic [3:0] req, input logic v, input logic [1:0] y);
        Req = req;
        V   = v;
        Y   = y;
        @(posedge clk);
        model_step(req, v, y);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Req   = 4'b1111;
        V     = 1'b1;
        Y     = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got G=%b O=%0d B=%b T=%b, want all zero", Grant, Owner, Busy, Timeout);
        end
        rst_n = 1'b1;
        tick(4'b1111, 1'b1, 2'b01);
        n_vec++;
        if (Grant !== 4'b0010 || Owner !== 2'd1 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_first_accept: got G=%b O=%0d B=%b T=%b, want %b", Grant, Owner, Busy, Timeout, model_vec());
        end
        tick(4'b0000, 1'b0, 2'b00);
        tick(4'b0000, 1'b0, 2'b00);
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_settle: got %b want %b", dut_vec(), model_vec());
        end
    endtask

    task automatic test_basic();
        tick(4'b0100, 1'b1, 2'b10);
        n_vec++;
        if (Grant !== 4'b0100 || Busy !== 1'b1 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL basic_grant: got G=%b B=%b all=%b want %b", Grant, Busy, dut_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) begin
            tick(4'b0100, 1'b0, 2'b00);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL basic_hold[%0d]: got %b want %b", i, dut_vec(), model_vec());
            end
        end
        tick(4'b0000, 1'b0, 2'b00);
        n_vec++;
        if (Grant !== 4'b0000 || Busy !== 1'b1 || Timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_release: got G=%b B=%b T=%b want G=0000 B=1 T=0", Grant, Busy, Timeout);
        end
        // A valid winner during the turnaround cycle must be ignored.
        tick(4'b0100, 1'b1, 2'b10);
        n_vec++;
        if (Grant !== 4'b0000 || Busy !== 1'b0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL basic_turn_gap: got G=%b B=%b want G=0000 B=0", Grant, Busy);
        end
        tick(4'b0100, 1'b1, 2'b10);
        n_vec++;
        if (Grant !== 4'b0100 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL basic_regrant: got %b want %b", dut_vec(), model_vec());
        end
        tick(4'b0000, 1'b0, 2'b00);
        tick(4'b0000, 1'b0, 2'b00);
    endtask

    task automatic test_timeout();
        int cnt;
        tick(4'b0001, 1'b1, 2'b00);
        cnt = 0;
        while (Grant === 4'b0001 && cnt < 40) begin
            cnt++;
            tick(4'b0001, 1'b0, 2'b00);
        end
        n_vec++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL timeout_length: got %0d grant cycles want 16", cnt);
        end
        n_vec++;
        if (Grant !== 4'b0000 || Timeout !== 1'b1 || Busy !== 1'b1 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL timeout_pulse: got G=%b T=%b B=%b want G=0000 T=1 B=1", Grant, Timeout, Busy);
        end
        tick(4'b0001, 1'b0, 2'b00);
        n_vec++;
        if (Timeout !== 1'b0 || Busy !== 1'b0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL timeout_single: got T=%b B=%b want T=0 B=0", Timeout, Busy);
        end
        tick(4'b0000, 1'b0, 2'b00);
    endtask

    task automatic test_simul();
        tick(4'b0001, 1'b1, 2'b00);
        for (int i = 0; i < 15; i++) tick(4'b0001, 1'b0, 2'b00);
        n_vec++;
        if (Grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL simul_before: got G=%b want 0001", Grant);
        end
        tick(4'b0000, 1'b0, 2'b00);
        n_vec++;
        if (Grant !== 4'b0000 || Timeout !== 1'b0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL simul_release_wins: got G=%b T=%b want G=0000 T=0", Grant, Timeout);
        end
        tick(4'b0000, 1'b0, 2'b00);
    endtask

    task automatic test_ignore_busy();
        tick(4'b1000, 1'b1, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick(4'b1001, 1'b1, 2'b00);
            n_vec++;
            if (Grant !== 4'b1000 || Owner !== 2'd3) begin
                n_bad++;
                $display("FAIL ignore_busy[%0d]: got G=%b O=%0d want G=1000 O=3", i, Grant, Owner);
            end
        end
        tick(4'b0001, 1'b1, 2'b00);
        tick(4'b0001, 1'b1, 2'b00);
        tick(4'b0001, 1'b1, 2'b00);
        n_vec++;
        if (Grant !== 4'b0001 || Owner !== 2'd0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL ignore_next_grant: got %b want %b", dut_vec(), model_vec());
        end
        tick(4'b0000, 1'b0, 2'b00);
        tick(4'b0000, 1'b0, 2'b00);
    endtask

    task automatic test_stale_reset();
        tick(4'b0000, 1'b1, 2'b01);
        tick(4'b0000, 1'b1, 2'b01);
        n_vec++;
        if (Grant !== 4'b0000 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_encode: got G=%b B=%b want G=0000 B=0", Grant, Busy);
        end
        tick(4'b0010, 1'b1, 2'b01);
        tick(4'b0010, 1'b0, 2'b00);
        n_vec++;
        if (Grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL stale_then_grant: got G=%b want 0010", Grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset_midgrant: got G=%b O=%0d B=%b T=%b want all zero", Grant, Owner, Busy, Timeout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4'b0000, 1'b0, 2'b00);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       v;
        logic [1:0] y;
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            v = 1'($urandom);
            y = 2'($urandom);
            tick(r, v, y);
            n_vec++;
            if (dut_vec() !== model_vec() || $countones(Grant) > 1) begin
                n_bad++;
                $display("FAIL random[%0d]: req=%b v=%b y=%0d got %b want %b", i, r, v, y, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        Req   = 4'b0000;
        V     = 1'b0;
        Y     = 2'b00;
        model_reset();
        test_reset();
        test_basic();
        test_timeout();
        test_simul();
        test_ignore_busy();
        test_stale_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
